wb_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: req 0 is the ALU/execute path, req 1 is the load/memory path.
- Each requester pushes {reg, data} into its own small FIFO using a valid/ready handshake.
- A round-robin arbiter drains one entry per cycle into registered WR_EN/WR_REG/WR_DATA outputs that drive the register file.
- A BUSY bitmap flags destination registers with writes still in flight, for hazard/interlock logic.

---
 rtl/legv8_pkg.sv | 13 +
 rtl/wb_fifo.sv | 63 ++++++
 rtl/wb_arbiter.sv | 111 +++++++++++
 tb/tb_wb_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 core types: register index, XZR index and writeback request.
package legv8_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int ZERO_REG   = 31;
    localparam int XLEN       = 64;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t         rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous writeback FIFO; exposes every slot's destination and valid bit
// so the arbiter can build the in-flight register bitmap.
module wb_fifo
    import legv8_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter int  ADDR_W  = REG_ADDR_W,
    parameter type entry_t = wb_req_t
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         flush,
    input  logic                         push,
    input  entry_t                       push_entry,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output entry_t                       head,
    output logic [DEPTH-1:0]             ent_vld,
    output logic [DEPTH-1:0][ADDR_W-1:0] ent_rd
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr, rd_ptr, count;
    logic           do_push, do_pop;
    entry_t         mem [DEPTH];

    // Extra MSB on each pointer is the wrap bit: equal addresses with differing wrap means full.
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
    end

    always_comb begin
        logic [PTR_W-1:0] offs;
        offs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs       = PTR_W'(i) - rd_ptr[PTR_W-1:0];
            ent_vld[i] = ({1'b0, offs} < count);
            ent_rd[i]  = mem[i].rd;
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin merge of the execute and memory writeback streams onto the single
// register file write port, with an in-flight destination bitmap for interlocks.
module wb_arbiter #(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = legv8_pkg::XLEN,
    parameter int ADDR_W   = legv8_pkg::REG_ADDR_W,
    parameter int ZERO_REG = legv8_pkg::ZERO_REG
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    input  logic                  REQ0_VALID,
    output logic                  REQ0_READY,
    input  logic [ADDR_W-1:0]     REQ0_REG,
    input  logic [DATA_W-1:0]     REQ0_DATA,
    input  logic                  REQ1_VALID,
    output logic                  REQ1_READY,
    input  logic [ADDR_W-1:0]     REQ1_REG,
    input  logic [DATA_W-1:0]     REQ1_DATA,
    output logic                  WR_EN,
    output logic [ADDR_W-1:0]     WR_REG,
    output logic [DATA_W-1:0]     WR_DATA,
    output logic [2**ADDR_W-1:0]  BUSY
);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic                         full0, full1, empty0, empty1;
    entry_t                       head0_p0, head1_p0, sel_p0;
    logic [DEPTH-1:0]             vld0, vld1;
    logic [DEPTH-1:0][ADDR_W-1:0] rd0, rd1;
    logic                         gnt0_p0, gnt1_p0, gnt_p0;
    logic                         last;
    logic                         vld_p1;
    logic [ADDR_W-1:0]            reg_p1;
    logic [DATA_W-1:0]            data_p1;

    assign REQ0_READY = !full0 && !RST;
    assign REQ1_READY = !full1 && !RST;

    wb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .entry_t(entry_t)) u_fifo0 (
        .CLK        (CLK),
        .RST        (RST),
        .flush      (FLUSH),
        .push       (REQ0_VALID && REQ0_READY),
        .push_entry ('{rd: REQ0_REG, data: REQ0_DATA}),
        .pop        (gnt0_p0),
        .full       (full0),
        .empty      (empty0),
        .head       (head0_p0),
        .ent_vld    (vld0),
        .ent_rd     (rd0)
    );

    wb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .entry_t(entry_t)) u_fifo1 (
        .CLK        (CLK),
        .RST        (RST),
        .flush      (FLUSH),
        .push       (REQ1_VALID && REQ1_READY),
        .push_entry ('{rd: REQ1_REG, data: REQ1_DATA}),
        .pop        (gnt1_p0),
        .full       (full1),
        .empty      (empty1),
        .head       (head1_p0),
        .ent_vld    (vld1),
        .ent_rd     (rd1)
    );

    // Stage p0: arbitrate FIFO heads; LAST names the requester granted most recently.
    assign gnt0_p0 = !FLUSH && !empty0 && (empty1 || last);
    assign gnt1_p0 = !FLUSH && !empty1 && (empty0 || !last);
    assign gnt_p0  = gnt0_p0 || gnt1_p0;
    assign sel_p0  = gnt1_p0 ? head1_p0 : head0_p0;

    // Stage p1: registered register-file write port.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last    <= 1'b1;
            vld_p1  <= 1'b0;
            reg_p1  <= '0;
            data_p1 <= '0;
        end else if (FLUSH) begin
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= gnt_p0 && (sel_p0.rd != ZERO_IDX);
            if (gnt_p0) begin
                last    <= gnt1_p0;
                reg_p1  <= sel_p0.rd;
                data_p1 <= sel_p0.data;
            end
        end
    end

    assign WR_EN   = vld_p1;
    assign WR_REG  = reg_p1;
    assign WR_DATA = data_p1;

    always_comb begin
        BUSY = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld0[i]) BUSY[rd0[i]] = 1'b1;
            if (vld1[i]) BUSY[rd1[i]] = 1'b1;
        end
        if (vld_p1) BUSY[reg_p1] = 1'b1;
        BUSY[ZERO_IDX] = 1'b0;
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: latency, contention, wrap, XZR, flush and async reset.
module tb_wb_arbiter;
    localparam int DEPTH    = 4;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 31;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 FLUSH;
    logic                 REQ0_VALID, REQ1_VALID;
    logic                 REQ0_READY, REQ1_READY;
    logic [ADDR_W-1:0]    REQ0_REG, REQ1_REG;
    logic [DATA_W-1:0]    REQ0_DATA, REQ1_DATA;
    logic                 WR_EN;
    logic [ADDR_W-1:0]    WR_REG;
    logic [DATA_W-1:0]    WR_DATA;
    logic [2**ADDR_W-1:0] BUSY;

    int n_checks = 0;
    int n_errors = 0;

    logic [ADDR_W-1:0] log_reg [$];
    logic [DATA_W-1:0] log_data[$];

    wb_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .FLUSH      (FLUSH),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_READY (REQ0_READY),
        .REQ0_REG   (REQ0_REG),
        .REQ0_DATA  (REQ0_DATA),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_READY (REQ1_READY),
        .REQ1_REG   (REQ1_REG),
        .REQ1_DATA  (REQ1_DATA),
        .WR_EN      (WR_EN),
        .WR_REG     (WR_REG),
        .WR_DATA    (WR_DATA),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (!RST && WR_EN) begin
            log_reg.push_back(WR_REG);
            log_data.push_back(WR_DATA);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; FLUSH = 1'b0;
        REQ0_VALID = 1'b0; REQ0_REG = '0; REQ0_DATA = '0;
        REQ1_VALID = 1'b0; REQ1_REG = '0; REQ1_DATA = '0;
        @(negedge CLK);
        check("rst_wr_en",   WR_EN,      0);
        check("rst_wr_reg",  WR_REG,     0);
        check("rst_wr_data", WR_DATA,    0);
        check("rst_busy",    BUSY,       0);
        check("rst_ready0",  REQ0_READY, 0);
        check("rst_ready1",  REQ1_READY, 0);
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic burst0(input int n, input int reg_base, input logic [63:0] data_base,
                          output int stalls);
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            int   g;
            logic rdy;
            g = 0;
            REQ0_VALID = 1'b1;
            REQ0_REG   = ADDR_W'(reg_base + i);
            REQ0_DATA  = data_base + 64'(i);
            do begin
                @(negedge CLK);
                rdy = REQ0_READY;
                next_cycle();
                if (!rdy) stalls++;
                g++;
            end while (!rdy && g < 50);
            if (!rdy) check("burst0_timeout", 0, 1);
        end
        REQ0_VALID = 1'b0;
    endtask

    task automatic burst1(input int n, input int reg_base, input logic [63:0] data_base,
                          output int stalls);
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            int   g;
            logic rdy;
            g = 0;
            REQ1_VALID = 1'b1;
            REQ1_REG   = ADDR_W'(reg_base + i);
            REQ1_DATA  = data_base + 64'(i);
            do begin
                @(negedge CLK);
                rdy = REQ1_READY;
                next_cycle();
                if (!rdy) stalls++;
                g++;
            end while (!rdy && g < 50);
            if (!rdy) check("burst1_timeout", 0, 1);
        end
        REQ1_VALID = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, s0, s1;

        // Single write: push in cycle 1, write port active in cycle 3.
        do_reset();
        REQ0_VALID = 1'b1; REQ0_REG = 5; REQ0_DATA = 64'hDEAD_BEEF;
        @(negedge CLK);
        check("t1_ready_c1", REQ0_READY, 1);
        check("t1_busy_c1",  BUSY,       0);
        next_cycle();
        REQ0_VALID = 1'b0;
        @(negedge CLK);
        check("t1_wr_en_c2", WR_EN,   0);
        check("t1_busy_c2",  BUSY[5], 1);
        next_cycle();
        @(negedge CLK);
        check("t1_wr_en_c3",   WR_EN,   1);
        check("t1_wr_reg_c3",  WR_REG,  5);
        check("t1_wr_data_c3", WR_DATA, 64'hDEAD_BEEF);
        check("t1_busy_c3",    BUSY,    32'h0000_0020);
        next_cycle();
        @(negedge CLK);
        check("t1_wr_en_c4",  WR_EN,  0);
        check("t1_busy_c4",   BUSY,   0);
        check("t1_hold_reg",  WR_REG, 5);

        // Contention: both push every cycle, output alternates starting with requester 0.
        do_reset();
        base = log_reg.size();
        fork
            burst0(8, 1, 64'hA00, s0);
            burst1(8, 9, 64'hB00, s1);
        join
        repeat (12) next_cycle();
        check("cont_count",   log_reg.size() - base, 16);
        check("cont_stall0",  s0, 1);
        check("cont_stall1",  s1, 2);
        for (int k = 0; k < 8; k++) begin
            if (base + 2*k + 1 < log_reg.size()) begin
                check($sformatf("cont_reg0_%0d", k),  log_reg[base+2*k],    k + 1);
                check($sformatf("cont_data0_%0d", k), log_data[base+2*k],   64'hA00 + 64'(k));
                check($sformatf("cont_reg1_%0d", k),  log_reg[base+2*k+1],  k + 9);
                check($sformatf("cont_data1_%0d", k), log_data[base+2*k+1], 64'hB00 + 64'(k));
            end
        end

        // Ten writes from requester 0 alone: order kept across pointer wrap.
        do_reset();
        base = log_reg.size();
        burst0(10, 1, 64'hC00, s0);
        repeat (5) next_cycle();
        check("wrap_count",  log_reg.size() - base, 10);
        check("wrap_stalls", s0, 0);
        for (int k = 0; k < 10; k++) begin
            if (base + k < log_reg.size()) begin
                check($sformatf("wrap_reg_%0d", k),  log_reg[base+k],  k + 1);
                check($sformatf("wrap_data_%0d", k), log_data[base+k], 64'hC00 + 64'(k));
            end
        end

        // XZR write consumes a slot without enabling the write port.
        do_reset();
        REQ1_VALID = 1'b1; REQ1_REG = 31; REQ1_DATA = 64'h1234;
        @(negedge CLK);
        check("xzr_busy_c1", BUSY, 0);
        next_cycle();
        REQ1_REG = 7; REQ1_DATA = 64'h55;
        @(negedge CLK);
        check("xzr_busy_c2", BUSY, 0);
        next_cycle();
        REQ1_VALID = 1'b0;
        @(negedge CLK);
        check("xzr_wr_en_c3", WR_EN, 0);
        check("xzr_busy_c3",  BUSY,  32'h0000_0080);
        next_cycle();
        @(negedge CLK);
        check("xzr_wr_en_c4",   WR_EN,   1);
        check("xzr_wr_reg_c4",  WR_REG,  7);
        check("xzr_wr_data_c4", WR_DATA, 64'h55);
        check("xzr_busy_c4",    BUSY,    32'h0000_0080);
        next_cycle();
        @(negedge CLK);
        check("xzr_wr_en_c5", WR_EN, 0);
        check("xzr_busy_c5",  BUSY,  0);

        // FLUSH with queued entries and a simultaneous push.
        do_reset();
        base = log_reg.size();
        for (int c = 0; c < 3; c++) begin
            REQ0_VALID = 1'b1; REQ0_REG = ADDR_W'(1 + c); REQ0_DATA = 64'hD0 + 64'(c);
            REQ1_VALID = 1'b1; REQ1_REG = ADDR_W'(9 + c); REQ1_DATA = 64'hE0 + 64'(c);
            next_cycle();
        end
        REQ0_REG = 20; REQ0_DATA = 64'hF00D;
        REQ1_VALID = 1'b0;
        FLUSH = 1'b1;
        @(negedge CLK);
        check("flush_staged_en",  WR_EN,  1);
        check("flush_staged_reg", WR_REG, 9);
        next_cycle();
        FLUSH = 1'b0; REQ0_VALID = 1'b0;
        @(negedge CLK);
        check("flush_wr_en",  WR_EN,      0);
        check("flush_busy",   BUSY,       0);
        check("flush_ready0", REQ0_READY, 1);
        check("flush_ready1", REQ1_READY, 1);
        repeat (6) next_cycle();
        check("flush_count", log_reg.size() - base, 2);

        // Async reset mid-stream, then first tie goes to requester 0.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            REQ0_VALID = 1'b1; REQ0_REG = ADDR_W'(1 + c); REQ0_DATA = 64'h100 + 64'(c);
            REQ1_VALID = 1'b1; REQ1_REG = ADDR_W'(9 + c); REQ1_DATA = 64'h200 + 64'(c);
            next_cycle();
        end
        @(negedge CLK);
        check("arst_pre_wr_en", WR_EN, 1);
        #2 RST = 1'b1;
        #1;
        check("arst_wr_en",  WR_EN,      0);
        check("arst_busy",   BUSY,       0);
        check("arst_ready0", REQ0_READY, 0);
        check("arst_ready1", REQ1_READY, 0);
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b0;
        REQ0_VALID = 1'b1; REQ0_REG = 4;  REQ0_DATA = 64'h44;
        REQ1_VALID = 1'b1; REQ1_REG = 12; REQ1_DATA = 64'hCC;
        next_cycle();
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        next_cycle();
        @(negedge CLK);
        check("arst_first_en",  WR_EN,  1);
        check("arst_first_reg", WR_REG, 4);
        next_cycle();
        @(negedge CLK);
        check("arst_second_en",  WR_EN,  1);
        check("arst_second_reg", WR_REG, 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
